cache_slave_responder: RTL and testbench
========================================

// Module: cache_slave_responder
// PURPOSE
//  Slave end of the cache interface 4-phase handshake: accepts READ/WRITE/INVALIDATE
//  from a master, services them from an internal direct-mapped line store, and
//  answers with valid (+ evict). Variable hit/miss latency. Sits behind the slave
//  modport; used as the cache model under test and as the responder in master benches.
// PARAMETERS
//  DATAWIDTH     8   data bus / line width in bits
//  ADDRESSWIDTH  32  address bus width
//  LINES         16  store depth, power of 2; INDEXBITS=$clog2(LINES), TAG=ADDRESSWIDTH-INDEXBITS
//  HIT_LATENCY   2   accept->valid cycles on hit and INVALIDATE (>=1)
//  MISS_LATENCY  5   accept->valid cycles on miss (>=1)
// PORTS
//  clock      in     1             system clock, rising edge
//  reset      in     1             synchronous, active-high
//  operation  in     inst_t        READ / WRITE / INVALIDATE (cachepkg); other codes = no-op
//  addr       in     ADDRESSWIDTH  request address; index=addr[INDEXBITS-1:0], tag=upper bits
//  data       inout  DATAWIDTH     write data from master; read data driven by this block
//  request    in     1             master 4-phase request
//  valid      out    1             response valid
//  evict      out    1             a valid line was displaced/removed; qualified by valid
// BEHAVIOUR
//  Reset (sync): state=IDLE, valid=0, evict=0, data released ('z), all line valid bits=0,
//   armed=0. Reset wins over any activity, including mid-transaction.
//  armed: set when request sampled 0; a request already high at reset exit is not
//   accepted until it has been seen low (no replay).
//  States:
//   IDLE: request=1 & armed -> capture op/addr/data, lookup, load counter
//     = (hit ? HIT_LATENCY : MISS_LATENCY)-1, clear armed, -> WAIT (or RESPOND if count 0).
//   WAIT: decrement; at 0 -> RESPOND. Counter width $clog2(max latency)+1.
//   RESPOND: valid=1 (registered; first high in cycle accept+latency). Hold until
//     request sampled 0, then valid=0, evict=0, data='z next cycle, -> IDLE.
//  Lookup: hit = line.valid & line.tag==captured tag. INVALIDATE always uses HIT_LATENCY.
//  Operations (store update on the cycle valid rises):
//   READ hit: data driven with line data while valid=1. READ miss: data driven all-0,
//     no allocation, evict=0.
//   WRITE: line <= {valid=1, tag, captured data} (write-allocate). evict=1 iff line
//     was valid with different tag. Same tag = overwrite, evict=0.
//   INVALIDATE: hit -> line.valid=0, evict=1; miss -> no change, evict=0.
//   No-op code: HIT_LATENCY, no store change, evict=0.
//  data bus: driven only in RESPOND for READ; else 'z. Write data sampled only at accept.
//  Master drops request before valid (protocol violation): transaction still completes;
//   valid pulses one cycle then returns low. Operands changing after accept are ignored.
//  Request re-raised while valid still high: not accepted until IDLE and armed.
//  One outstanding transaction; no pipelining.
// TESTING
//  1 Reset, WRITE addr=0x13 data=0xA5 -> valid at accept+5 (miss), evict=0; drop req ->
//    valid=0 next cycle.
//  2 READ 0x13 -> valid at accept+2, data=0xA5, evict=0; READ 0x23 (same index, tag diff)
//    -> accept+5, data=0x00.
//  3 WRITE 0x23 data=0x3C after test1 -> evict=1 with valid; READ 0x13 -> miss, 0x00;
//    READ 0x23 -> 0x3C.
//  4 INVALIDATE 0x23 -> accept+2, evict=1; repeat -> evict=0; READ 0x23 -> miss latency.
//  5 Assert reset in WAIT of READ 0x13 with request held high -> valid stays 0, no
//    accept until request low then high; READ then misses (store cleared).
//  6 Master drops request at accept+1 of READ hit -> valid high exactly 1 cycle at accept+2.

Source files
------------

// File: rtl/cache_slave_responder.sv
// Slave side of the cache 4-phase handshake, backed by a direct-mapped line store.
// Hits and INVALIDATE answer after HIT_LATENCY cycles, misses after MISS_LATENCY cycles.
package cachepkg;
    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        INVALIDATE = 2'd2
    } inst_t;
endpackage

module cache_slave_responder
    import cachepkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int LINES        = 16,
    parameter int HIT_LATENCY  = 2,
    parameter int MISS_LATENCY = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  inst_t                   operation,
    input  logic [ADDRESSWIDTH-1:0] addr,
    inout  wire  [DATAWIDTH-1:0]    data,
    input  logic                    request,
    output logic                    valid,
    output logic                    evict
);
    localparam int INDEXBITS = $clog2(LINES);
    localparam int TAGBITS   = ADDRESSWIDTH - INDEXBITS;
    localparam int MAXLAT    = (HIT_LATENCY > MISS_LATENCY) ? HIT_LATENCY : MISS_LATENCY;
    localparam int CNTW      = $clog2(MAXLAT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t                  state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    inst_t                   op_q, op_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
    logic                    valid_q, valid_d;
    logic                    evict_q, evict_d;
    logic                    drive_q, drive_d;
    logic [DATAWIDTH-1:0]    rdata_q, rdata_d;

    logic [LINES-1:0]        line_valid_q, line_valid_d;
    logic [TAGBITS-1:0]      line_tag_q  [LINES];
    logic [TAGBITS-1:0]      line_tag_d  [LINES];
    logic [DATAWIDTH-1:0]    line_data_q [LINES];
    logic [DATAWIDTH-1:0]    line_data_d [LINES];

    logic [ADDRESSWIDTH-1:0] lk_addr;
    logic [INDEXBITS-1:0]    lk_idx;
    logic [TAGBITS-1:0]      lk_tag;
    logic                    lk_hit;
    logic [CNTW-1:0]         lk_lat;

    // Lookup uses the live address while idle and the captured one afterwards;
    // the store cannot change between accept and response.
    always_comb begin
        lk_addr = (state_q == IDLE) ? addr : addr_q;
        lk_idx  = lk_addr[INDEXBITS-1:0];
        lk_tag  = lk_addr[ADDRESSWIDTH-1:INDEXBITS];
        lk_hit  = line_valid_q[lk_idx] && (line_tag_q[lk_idx] == lk_tag);
        case (operation)
            READ, WRITE: lk_lat = lk_hit ? CNTW'(HIT_LATENCY - 1) : CNTW'(MISS_LATENCY - 1);
            default:     lk_lat = CNTW'(HIT_LATENCY - 1);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q | ~request;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        evict_d      = evict_q;
        drive_d      = drive_q;
        rdata_d      = rdata_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        case (state_q)
            IDLE: begin
                if (request && armed_q) begin
                    op_d    = operation;
                    addr_d  = addr;
                    wdata_d = data;
                    cnt_d   = lk_lat;
                    armed_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESPOND;
                    valid_d = 1'b1;
                    evict_d = 1'b0;
                    case (op_q)
                        READ: begin
                            drive_d = 1'b1;
                            rdata_d = lk_hit ? line_data_q[lk_idx] : '0;
                        end
                        WRITE: begin
                            evict_d              = line_valid_q[lk_idx] && !lk_hit;
                            line_valid_d[lk_idx] = 1'b1;
                            line_tag_d[lk_idx]   = lk_tag;
                            line_data_d[lk_idx]  = wdata_q;
                        end
                        INVALIDATE: begin
                            if (lk_hit) begin
                                evict_d              = 1'b1;
                                line_valid_d[lk_idx] = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: begin
                if (!request) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    evict_d = 1'b0;
                    drive_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            valid_q      <= 1'b0;
            evict_q      <= 1'b0;
            drive_q      <= 1'b0;
            line_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            valid_q      <= valid_d;
            evict_q      <= evict_d;
            drive_q      <= drive_d;
            line_valid_q <= line_valid_d;
        end
        op_q        <= op_d;
        addr_q      <= addr_d;
        wdata_q     <= wdata_d;
        rdata_q     <= rdata_d;
        line_tag_q  <= line_tag_d;
        line_data_q <= line_data_d;
    end

    assign valid = valid_q;
    assign evict = evict_q;
    assign data  = drive_q ? rdata_q : 'z;
endmodule

// File: tb/tb_cache_slave_responder.sv
// Bench for cache_slave_responder: directed scenarios plus random traffic,
// checked against an abstract array model of the line store.
module tb_cache_slave_responder;
    import cachepkg::*;

    logic        clock = 1'b0;
    logic        reset;
    inst_t       operation;
    logic [31:0] addr;
    logic        request;
    logic        valid;
    logic        evict;
    logic [7:0]  tb_data;
    logic        tb_drv;
    wire  [7:0]  data;

    assign data = tb_drv ? tb_data : 'z;

    cache_slave_responder dut (
        .clock     (clock),
        .reset     (reset),
        .operation (operation),
        .addr      (addr),
        .data      (data),
        .request   (request),
        .valid     (valid),
        .evict     (evict)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    bit         m_valid [16];
    logic [27:0] m_tag  [16];
    logic [7:0]  m_data [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One full well-behaved transaction: expected latency, evict and read data
    // come from the model, which is then updated.
    task automatic txn(input inst_t op, input logic [31:0] a, input logic [7:0] wd);
        int          idx, n, exp_lat;
        logic [27:0] tg;
        bit          hit, exp_ev;
        logic [7:0]  exp_rd;
        idx    = a % 16;
        tg     = 28'(a / 16);
        hit    = m_valid[idx] && (m_tag[idx] == tg);
        exp_ev = 1'b0;
        exp_rd = 8'h00;
        exp_lat = 2;
        case (op)
            READ: begin
                exp_lat = hit ? 2 : 5;
                exp_rd  = hit ? m_data[idx] : 8'h00;
            end
            WRITE: begin
                exp_lat = hit ? 2 : 5;
                exp_ev  = m_valid[idx] && !hit;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = wd;
            end
            INVALIDATE: begin
                exp_ev = hit;
                if (hit) m_valid[idx] = 1'b0;
            end
            default: ;
        endcase

        @(negedge clock);
        operation = op;
        addr      = a;
        tb_data   = wd;
        tb_drv    = (op == WRITE);
        request   = 1'b1;
        @(posedge clock); #1;
        n = 0;
        while (!valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check($sformatf("lat op%0d a%0h", op, a), n, exp_lat);
        check($sformatf("evict op%0d a%0h", op, a), evict, exp_ev);
        if (op == READ) check($sformatf("rdata a%0h", a), data, exp_rd);
        // scramble operands after accept; response must not change
        @(negedge clock);
        addr    = $urandom;
        tb_data = 8'($urandom);
        @(posedge clock); #1;
        check("valid_hold", valid, 1'b1);
        if (op == READ) check("rdata_hold", data, exp_rd);
        @(negedge clock);
        request = 1'b0;
        tb_drv  = 1'b0;
        @(posedge clock); #1;
        check("valid_drop", valid, 1'b0);
        check("evict_drop", evict, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        request   = 1'b0;
        operation = READ;
        addr      = '0;
        tb_data   = '0;
        tb_drv    = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", valid, 1'b0);
        check("rst_evict", evict, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // write-allocate, hit/miss reads, conflicting write, invalidate
        txn(WRITE, 32'h13, 8'hA5);
        txn(READ,  32'h13, 8'h00);
        txn(READ,  32'h23, 8'h00);
        txn(WRITE, 32'h23, 8'h3C);
        txn(READ,  32'h13, 8'h00);
        txn(READ,  32'h23, 8'h00);
        txn(INVALIDATE, 32'h23, 8'h00);
        txn(INVALIDATE, 32'h23, 8'h00);
        txn(READ,  32'h23, 8'h00);
        txn(inst_t'(2'd3), 32'h13, 8'h00);

        // reset mid-WAIT with request held high
        txn(WRITE, 32'h13, 8'h77);
        @(negedge clock);
        operation = READ;
        addr      = 32'h13;
        request   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clock); #1;
                if (valid) seen++;
            end
            check("no_replay_after_reset", seen, 0);
        end
        @(negedge clock);
        request = 1'b0;
        @(posedge clock); #1;
        txn(READ, 32'h13, 8'h00);

        // request dropped before valid on a read hit
        txn(WRITE, 32'h15, 8'h5E);
        @(negedge clock);
        operation = READ;
        addr      = 32'h15;
        request   = 1'b1;
        @(posedge clock); #1;
        check("early_k0", valid, 1'b0);
        @(negedge clock);
        request = 1'b0;
        @(posedge clock); #1;
        check("early_k1", valid, 1'b0);
        @(posedge clock); #1;
        check("early_k2_valid", valid, 1'b1);
        check("early_k2_data", data, 8'h5E);
        @(posedge clock); #1;
        check("early_k3", valid, 1'b0);
        @(posedge clock); #1;
        check("early_k4", valid, 1'b0);

        // random traffic over a few indices and tags to force hits and conflicts
        for (int t = 0; t < 60; t++) begin
            inst_t       op;
            logic [31:0] a;
            op = inst_t'($urandom_range(0, 3));
            a  = ($urandom_range(0, 2) << 4) | $urandom_range(0, 3);
            txn(op, a, 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
